// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the 4-bit CPU timing/control unit: opcodes,
// ring-counter T-state indices, control-word layout and FSM states.
package ctrl_pkg;

  localparam int unsigned RING_W = 6;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_CLA = 4'h3;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int unsigned T1_IDX = 0;
  localparam int unsigned T2_IDX = 1;
  localparam int unsigned T3_IDX = 2;
  localparam int unsigned T4_IDX = 3;
  localparam int unsigned T5_IDX = 4;
  localparam int unsigned T6_IDX = 5;

  // Field order matches the output port order of control_sequencer.
  typedef struct packed {
    logic pc_enable;
    logic pc_inc;
    logic mar_latch;
    logic ram_enable;
    logic ir_latch;
    logic ir_enable;
    logic latch_a;
    logic enable_a;
    logic clear_a;
    logic latch_b;
    logic alu_sub;
    logic alu_enable;
    logic out_latch;
  } ctrl_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/control_sequencer_ring_counter.sv
// One-hot T-state ring: async clear, sync clear, sync restart at T1, shift.
module ring_counter
  import ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              restart_i,
  input  logic              advance_i,
  output logic [RING_W-1:0] ring_o
);

  logic [RING_W-1:0] ring_q;

  // Ring register; clear has priority over restart, restart over advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ring_q <= '0;
    end else if (clear_i) begin
      ring_q <= '0;
    end else if (restart_i) begin
      ring_q <= RING_W'(1);
    end else if (advance_i) begin
      ring_q <= {ring_q[RING_W-2:0], ring_q[RING_W-1]};
    end
  end

  assign ring_o = ring_q;

endmodule

// File: rtl/control_sequencer.sv
// Timing and control unit: IDLE/RUN/HALT FSM around a one-hot T1..T6 ring,
// with a combinational control-word decode of ring + opcode.
// Optional feature macro SHORT_CYCLE_EN: instructions end after their last
// active T-state instead of always running to T6.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_WIDTH        = 4,
  parameter bit          HALT_ON_UNKNOWN = 1'b0
) (
  input  logic                MainClock,
  input  logic                ClearN,
  input  logic                Run,
  input  logic [OP_WIDTH-1:0] Opcode,
  output logic                PcEnable,
  output logic                PcInc,
  output logic                MarLatch,
  output logic                RamEnable,
  output logic                IrLatch,
  output logic                IrEnable,
  output logic                LatchA,
  output logic                EnableA,
  output logic                ClearA,
  output logic                LatchB,
  output logic                AluSub,
  output logic                AluEnable,
  output logic                OutLatch,
  output logic [2:0]          TState,
  output logic                Halted
);

  localparam logic [OP_WIDTH-1:0] LDA = OP_WIDTH'(OP_LDA);
  localparam logic [OP_WIDTH-1:0] ADD = OP_WIDTH'(OP_ADD);
  localparam logic [OP_WIDTH-1:0] SUB = OP_WIDTH'(OP_SUB);
  localparam logic [OP_WIDTH-1:0] CLA = OP_WIDTH'(OP_CLA);
  localparam logic [OP_WIDTH-1:0] OUT = OP_WIDTH'(OP_OUT);
  localparam logic [OP_WIDTH-1:0] HLT = OP_WIDTH'(OP_HLT);

  seq_state_e        state_q, state_d;
  logic [RING_W-1:0] ring;
  logic              ring_clear, ring_restart, ring_advance;
  logic              is_known, is_halt, end_instr;
  ctrl_word_t        cw;

  ring_counter u_ring (
    .clk_i     (MainClock),
    .rst_ni    (ClearN),
    .clear_i   (ring_clear),
    .restart_i (ring_restart),
    .advance_i (ring_advance),
    .ring_o    (ring)
  );

  // Opcode classification and end-of-instruction detection.
  always_comb begin
    is_known = (Opcode == LDA) || (Opcode == ADD) || (Opcode == SUB) ||
               (Opcode == CLA) || (Opcode == OUT) || (Opcode == HLT);
    is_halt  = (Opcode == HLT) || (HALT_ON_UNKNOWN && !is_known);
    end_instr = ring[T6_IDX];
`ifdef SHORT_CYCLE_EN
    // A NOP cannot be recognised before T4 (IR is refilled at the T3 edge),
    // so the earliest point it can end is after T4.
    end_instr = ring[T6_IDX] ||
                (ring[T5_IDX] && (Opcode == LDA)) ||
                (ring[T4_IDX] && ((Opcode == CLA) || (Opcode == OUT) || !is_known));
`endif
  end

  // Next-state and ring control.
  always_comb begin
    state_d      = state_q;
    ring_clear   = 1'b0;
    ring_restart = 1'b0;
    ring_advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Run) begin
          state_d      = ST_RUN;
          ring_restart = 1'b1;
        end
      end
      ST_RUN: begin
        if (ring[T4_IDX] && is_halt) begin
          state_d    = ST_HALT;
          ring_clear = 1'b1;
        end else if (end_instr) begin
          if (Run) begin
            ring_restart = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            ring_clear = 1'b1;
          end
        end else begin
          ring_advance = 1'b1;
        end
      end
      ST_HALT: begin
        ring_clear = 1'b1;
      end
      default: begin
        state_d    = ST_IDLE;
        ring_clear = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge MainClock or negedge ClearN) begin
    if (!ClearN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control-word decode of the one-hot ring and opcode.
  always_comb begin
    cw = '0;
    if (ring[T1_IDX]) begin
      cw.pc_enable = 1'b1;
      cw.mar_latch = 1'b1;
    end
    if (ring[T2_IDX]) begin
      cw.pc_inc = 1'b1;
    end
    if (ring[T3_IDX]) begin
      cw.ram_enable = 1'b1;
      cw.ir_latch   = 1'b1;
    end
    if (ring[T4_IDX]) begin
      if ((Opcode == LDA) || (Opcode == ADD) || (Opcode == SUB)) begin
        cw.ir_enable = 1'b1;
        cw.mar_latch = 1'b1;
      end
      if (Opcode == CLA) cw.clear_a = 1'b1;
      if (Opcode == OUT) begin
        cw.enable_a  = 1'b1;
        cw.out_latch = 1'b1;
      end
    end
    if (ring[T5_IDX]) begin
      if (Opcode == LDA) begin
        cw.ram_enable = 1'b1;
        cw.latch_a    = 1'b1;
      end
      if ((Opcode == ADD) || (Opcode == SUB)) begin
        cw.ram_enable = 1'b1;
        cw.latch_b    = 1'b1;
        cw.alu_sub    = (Opcode == SUB);
      end
    end
    if (ring[T6_IDX]) begin
      if ((Opcode == ADD) || (Opcode == SUB)) begin
        cw.alu_enable = 1'b1;
        cw.latch_a    = 1'b1;
        cw.alu_sub    = (Opcode == SUB);
      end
    end
  end

  // T-state number from the one-hot ring (0 when no bit is set).
  always_comb begin
    TState = 3'd0;
    for (int unsigned i = 0; i < RING_W; i++) begin
      if (ring[i]) TState = 3'(i + 1);
    end
  end

  assign Halted = (state_q == ST_HALT);

  assign {PcEnable, PcInc, MarLatch, RamEnable, IrLatch, IrEnable, LatchA,
          EnableA, ClearA, LatchB, AluSub, AluEnable, OutLatch} = cw;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer (default instance plus one with
// HALT_ON_UNKNOWN=1).
module tb_control_sequencer;

  localparam logic [12:0] PCE  = 13'h1000;
  localparam logic [12:0] PCI  = 13'h0800;
  localparam logic [12:0] MARL = 13'h0400;
  localparam logic [12:0] RAME = 13'h0200;
  localparam logic [12:0] IRL  = 13'h0100;
  localparam logic [12:0] IRE  = 13'h0080;
  localparam logic [12:0] LA   = 13'h0040;
  localparam logic [12:0] EA   = 13'h0020;
  localparam logic [12:0] CA   = 13'h0010;
  localparam logic [12:0] LB   = 13'h0008;
  localparam logic [12:0] SUBS = 13'h0004;
  localparam logic [12:0] ALUE = 13'h0002;
  localparam logic [12:0] OUTL = 13'h0001;

  logic       clk = 1'b0;
  logic       clear_n, run;
  logic [3:0] opcode;
  logic       clear_n_h, run_h;
  logic [3:0] opcode_h;

  logic [12:0] outs, outs_h;
  logic [2:0]  tstate, tstate_h;
  logic        halted, halted_h;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_sequencer #(.OP_WIDTH(4), .HALT_ON_UNKNOWN(1'b0)) u_dut (
    .MainClock(clk), .ClearN(clear_n), .Run(run), .Opcode(opcode),
    .PcEnable(outs[12]), .PcInc(outs[11]), .MarLatch(outs[10]),
    .RamEnable(outs[9]), .IrLatch(outs[8]), .IrEnable(outs[7]),
    .LatchA(outs[6]), .EnableA(outs[5]), .ClearA(outs[4]), .LatchB(outs[3]),
    .AluSub(outs[2]), .AluEnable(outs[1]), .OutLatch(outs[0]),
    .TState(tstate), .Halted(halted)
  );

  control_sequencer #(.OP_WIDTH(4), .HALT_ON_UNKNOWN(1'b1)) u_dut_h (
    .MainClock(clk), .ClearN(clear_n_h), .Run(run_h), .Opcode(opcode_h),
    .PcEnable(outs_h[12]), .PcInc(outs_h[11]), .MarLatch(outs_h[10]),
    .RamEnable(outs_h[9]), .IrLatch(outs_h[8]), .IrEnable(outs_h[7]),
    .LatchA(outs_h[6]), .EnableA(outs_h[5]), .ClearA(outs_h[4]), .LatchB(outs_h[3]),
    .AluSub(outs_h[2]), .AluEnable(outs_h[1]), .OutLatch(outs_h[0]),
    .TState(tstate_h), .Halted(halted_h)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check TState, control outputs and Halted of the default instance.
  task automatic chk_all(input string tag, input logic [2:0] t, input logic [12:0] o,
                         input logic h);
    chk({tag, ".tstate"}, 16'(tstate), 16'(t));
    chk({tag, ".outs"},   16'(outs),   16'(o));
    chk({tag, ".halted"}, 16'(halted), 16'(h));
  endtask

  initial begin
    clear_n = 1'b0; run = 1'b1; opcode = 4'h1;
    clear_n_h = 1'b0; run_h = 1'b0; opcode_h = 4'h7;

    // Reset held for two edges with Run high.
    step(); step();
    chk_all("reset", 3'd0, 13'h0, 1'b0);
    clear_n = 1'b1;

    // ADD: full six states, then back to T1.
    step(); chk_all("add.t1", 3'd1, PCE | MARL, 1'b0);
    step(); chk_all("add.t2", 3'd2, PCI, 1'b0);
    step(); chk_all("add.t3", 3'd3, RAME | IRL, 1'b0);
    step(); chk_all("add.t4", 3'd4, IRE | MARL, 1'b0);
    step(); chk_all("add.t5", 3'd5, RAME | LB, 1'b0);
    step(); chk_all("add.t6", 3'd6, ALUE | LA, 1'b0);
    step(); chk_all("add.next", 3'd1, PCE | MARL, 1'b0);

    // SUB: AluSub only in T5/T6.
    opcode = 4'h2;
    step(); chk_all("sub.t2", 3'd2, PCI, 1'b0);
    step(); chk_all("sub.t3", 3'd3, RAME | IRL, 1'b0);
    step(); chk_all("sub.t4", 3'd4, IRE | MARL, 1'b0);
    step(); chk_all("sub.t5", 3'd5, RAME | LB | SUBS, 1'b0);
    step(); chk_all("sub.t6", 3'd6, ALUE | LA | SUBS, 1'b0);
    step(); chk_all("sub.next", 3'd1, PCE | MARL, 1'b0);

    // CLA: ClearA only in T4.
    opcode = 4'h3;
    step(); step();
    step(); chk_all("cla.t4", 3'd4, CA, 1'b0);
`ifdef SHORT_CYCLE_EN
    step(); chk_all("cla.next", 3'd1, PCE | MARL, 1'b0);
`else
    step(); chk_all("cla.t5", 3'd5, 13'h0, 1'b0);
    step(); chk_all("cla.t6", 3'd6, 13'h0, 1'b0);
    step(); chk_all("cla.next", 3'd1, PCE | MARL, 1'b0);
`endif

    // OUT: 4-cycle instruction with the short-cycle feature, 6 otherwise.
    opcode = 4'hE;
    step(); step();
    step(); chk_all("out.t4", 3'd4, EA | OUTL, 1'b0);
`ifdef SHORT_CYCLE_EN
    step(); chk_all("out.next", 3'd1, PCE | MARL, 1'b0);
`else
    step(); chk_all("out.t5", 3'd5, 13'h0, 1'b0);
    step(); chk_all("out.t6", 3'd6, 13'h0, 1'b0);
    step(); chk_all("out.next", 3'd1, PCE | MARL, 1'b0);
`endif

    // LDA with Run dropped in T2: instruction completes, then idle.
    opcode = 4'h0;
    step(); chk_all("lda.t2", 3'd2, PCI, 1'b0);
    run = 1'b0;
    step(); chk_all("lda.t3", 3'd3, RAME | IRL, 1'b0);
    step(); chk_all("lda.t4", 3'd4, IRE | MARL, 1'b0);
    step(); chk_all("lda.t5", 3'd5, RAME | LA, 1'b0);
`ifndef SHORT_CYCLE_EN
    step(); chk_all("lda.t6", 3'd6, 13'h0, 1'b0);
`endif
    step(); chk_all("lda.idle", 3'd0, 13'h0, 1'b0);
    step(); chk_all("idle.hold", 3'd0, 13'h0, 1'b0);
    run = 1'b1;
    step(); chk_all("idle.start", 3'd1, PCE | MARL, 1'b0);

    // HLT: halts after T4, Run ignored until reset.
    opcode = 4'hF;
    step(); step();
    step(); chk_all("hlt.t4", 3'd4, 13'h0, 1'b0);
    step(); chk_all("hlt.halt", 3'd0, 13'h0, 1'b1);
    run = 1'b0;
    step(); chk_all("hlt.run0", 3'd0, 13'h0, 1'b1);
    run = 1'b1;
    step(); chk_all("hlt.run1", 3'd0, 13'h0, 1'b1);
    #2 clear_n = 1'b0;
    #1 chk_all("hlt.clear", 3'd0, 13'h0, 1'b0);
    clear_n = 1'b1;
    step(); chk_all("hlt.restart", 3'd1, PCE | MARL, 1'b0);

    // Async reset in T5 of LDA, between clock edges.
    opcode = 4'h0;
    step(); step(); step();
    step(); chk_all("rst.t5", 3'd5, RAME | LA, 1'b0);
    #2 clear_n = 1'b0;
    #1 chk_all("rst.async", 3'd0, 13'h0, 1'b0);
    clear_n = 1'b1;

    // Unknown opcode on the default instance behaves as NOP.
    opcode = 4'h7;
    step(); chk_all("nop.t1", 3'd1, PCE | MARL, 1'b0);
    step(); step();
    step(); chk_all("nop.t4", 3'd4, 13'h0, 1'b0);
`ifdef SHORT_CYCLE_EN
    step(); chk_all("nop.next", 3'd1, PCE | MARL, 1'b0);
`else
    step(); step();
    step(); chk_all("nop.next", 3'd1, PCE | MARL, 1'b0);
`endif

    // Unknown opcode with HALT_ON_UNKNOWN=1 halts at T4.
    run_h = 1'b1; clear_n_h = 1'b1;
    step(); chk("unk.t1", 16'(tstate_h), 16'd1);
    step(); step();
    step(); chk("unk.t4", 16'(tstate_h), 16'd4);
    chk("unk.t4.outs", 16'(outs_h), 16'h0);
    step(); chk("unk.halt.t", 16'(tstate_h), 16'd0);
    chk("unk.halt.h", 16'(halted_h), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
